// File: rtl/ntt_bank_mapper.sv
// ntt_bank_mapper
//   Sits behind the NTT address generator. Each valid cycle it takes one
//   radix-16 group (16 lane indices plus the stage number), maps every index
//   to a memory bank (radix-16 digit sum mod 16) and an in-bank address, then
//   builds the bank-side read crossbar and the lane-side write-back
//   permutation. Two-stage pipeline, no stall. Flags bank conflicts and
//   out-of-range indices (sticky) and counts groups within a stage.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   in_valid_i     group valid
//   in_order_i     lane k index at [k*D_WIDTH +: D_WIDTH]
//   in_stage_i     stage number of this group
//   in_done_i      one-cycle pulse after the last group of the last stage
//   out_valid_o    mapped group valid (two cycles after in_valid_i)
//   bank_addr_o    bank b read address at [b*ADDR_W +: ADDR_W]
//   bank_lane_o    lane whose index landed in bank b, at [b*4 +: 4]
//   lane_bank_o    bank assigned to lane k, at [k*4 +: 4]
//   out_stage_o    stage number aligned with out_valid_o
//   out_done_o     in_done_i delayed two cycles
//   grp_cnt_o      group number within the current stage
//   stage_last_o   pulses with out_valid_o on the last group of a stage
//   conflict_err_o sticky: two lanes of one group hit the same bank
//   range_err_o    sticky: an index had bits set at or above LOGN
module ntt_bank_mapper #(
  parameter int D_WIDTH = 12,
  parameter int LOGN    = 12,
  parameter int LANES   = 16,
  parameter int ADDR_W  = LOGN - 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  input  logic [LANES*D_WIDTH-1:0]  in_order_i,
  input  logic [D_WIDTH-1:0]        in_stage_i,
  input  logic                      in_done_i,
  output logic                      out_valid_o,
  output logic [LANES*ADDR_W-1:0]   bank_addr_o,
  output logic [LANES*4-1:0]        bank_lane_o,
  output logic [LANES*4-1:0]        lane_bank_o,
  output logic [D_WIDTH-1:0]        out_stage_o,
  output logic                      out_done_o,
  output logic [ADDR_W-1:0]         grp_cnt_o,
  output logic                      stage_last_o,
  output logic                      conflict_err_o,
  output logic                      range_err_o
);

  localparam int DIGITS = LOGN / 4;

  // ---------------- S1: per-lane bank / address mapping ----------------
  logic [3:0]        bank_d [LANES];
  logic [ADDR_W-1:0] addr_d [LANES];
  logic [LANES-1:0]  hi_d;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [D_WIDTH-1:0] raw;
    logic [LOGN-1:0]    idx;
    logic [3:0]         dsum;

    assign raw = in_order_i[k*D_WIDTH +: D_WIDTH];
    assign idx = raw[LOGN-1:0];

    // Truncating the full-width digit sum to 4 bits is the same as
    // accumulating modulo 16, so the accumulator is kept 4 bits wide.
    always_comb begin
      dsum = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
        dsum = dsum + idx[4*i +: 4];
      end
    end

    assign bank_d[k] = dsum;
    assign addr_d[k] = idx[LOGN-1:4];
    // Shifting by the full width yields zero, so this also covers D_WIDTH == LOGN.
    assign hi_d[k]   = (raw >> LOGN) != '0;
  end

  logic              s1_valid_q;
  logic              s1_done_q;
  logic [D_WIDTH-1:0] s1_stage_q;
  logic [3:0]        s1_bank_q [LANES];
  logic [ADDR_W-1:0] s1_addr_q [LANES];
  logic              range_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_done_q   <= 1'b0;
      s1_stage_q  <= '0;
      range_err_q <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        s1_bank_q[k] <= '0;
        s1_addr_q[k] <= '0;
      end
    end else begin
      s1_valid_q <= in_valid_i;
      s1_done_q  <= in_done_i;
      if (in_valid_i) begin
        s1_stage_q <= in_stage_i;
        for (int k = 0; k < LANES; k++) begin
          s1_bank_q[k] <= bank_d[k];
          s1_addr_q[k] <= addr_d[k];
        end
        if (|hi_d) range_err_q <= 1'b1;
      end
    end
  end

  // ---------------- S2: crossbar, conflict check, group count ----------------
  logic [3:0]        xb_lane_d [LANES];
  logic [ADDR_W-1:0] xb_addr_d [LANES];
  logic [LANES-1:0]  used_d;

  always_comb begin
    used_d = '0;
    for (int b = 0; b < LANES; b++) begin
      xb_lane_d[b] = '0;
      xb_addr_d[b] = '0;
      // Scan from the top so the lowest matching lane is the last write.
      for (int k = LANES - 1; k >= 0; k--) begin
        if (s1_bank_q[k] == 4'(b)) begin
          xb_lane_d[b] = 4'(k);
          xb_addr_d[b] = s1_addr_q[k];
        end
      end
    end
    for (int k = 0; k < LANES; k++) begin
      used_d[s1_bank_q[k]] = 1'b1;
    end
  end

  logic [ADDR_W-1:0]  cnt_q;
  logic [D_WIDTH-1:0] prev_stage_q;
  logic [ADDR_W-1:0]  grp_eff;

  // A group whose stage differs from the previous valid group restarts at 0.
  assign grp_eff = (s1_stage_q != prev_stage_q) ? '0 : cnt_q;

  logic              out_valid_q;
  logic              out_done_q;
  logic              stage_last_q;
  logic              conflict_err_q;
  logic [D_WIDTH-1:0] out_stage_q;
  logic [ADDR_W-1:0] grp_cnt_q;
  logic [3:0]        bank_lane_q [LANES];
  logic [ADDR_W-1:0] bank_addr_q [LANES];
  logic [3:0]        lane_bank_q [LANES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q    <= 1'b0;
      out_done_q     <= 1'b0;
      stage_last_q   <= 1'b0;
      conflict_err_q <= 1'b0;
      out_stage_q    <= '0;
      grp_cnt_q      <= '0;
      cnt_q          <= '0;
      prev_stage_q   <= '0;
      for (int b = 0; b < LANES; b++) begin
        bank_lane_q[b] <= '0;
        bank_addr_q[b] <= '0;
        lane_bank_q[b] <= '0;
      end
    end else begin
      out_valid_q  <= s1_valid_q;
      out_done_q   <= s1_done_q;
      stage_last_q <= s1_valid_q && (grp_eff == '1);
      if (s1_valid_q) begin
        out_stage_q  <= s1_stage_q;
        prev_stage_q <= s1_stage_q;
        grp_cnt_q    <= grp_eff;
        for (int b = 0; b < LANES; b++) begin
          bank_lane_q[b] <= xb_lane_d[b];
          bank_addr_q[b] <= xb_addr_d[b];
          lane_bank_q[b] <= s1_bank_q[b];
        end
        // 16 lanes into 16 banks are distinct exactly when every bank is hit.
        if (!(&used_d)) conflict_err_q <= 1'b1;
      end else if (s1_done_q) begin
        grp_cnt_q <= '0;
      end
      if (s1_done_q) begin
        cnt_q <= '0;
      end else if (s1_valid_q) begin
        cnt_q <= grp_eff + 1'b1;
      end
    end
  end

  for (genvar b = 0; b < LANES; b++) begin : g_out
    assign bank_addr_o[b*ADDR_W +: ADDR_W] = bank_addr_q[b];
    assign bank_lane_o[b*4 +: 4]           = bank_lane_q[b];
    assign lane_bank_o[b*4 +: 4]           = lane_bank_q[b];
  end

  assign out_valid_o    = out_valid_q;
  assign out_stage_o    = out_stage_q;
  assign out_done_o     = out_done_q;
  assign grp_cnt_o      = grp_cnt_q;
  assign stage_last_o   = stage_last_q;
  assign conflict_err_o = conflict_err_q;
  assign range_err_o    = range_err_q;

endmodule

// File: tb/tb_ntt_bank_mapper.sv
module tb_ntt_bank_mapper;

  localparam int DW   = 16;
  localparam int LOGN = 12;
  localparam int L    = 16;
  localparam int AW   = LOGN - 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [L*DW-1:0] in_order;
  logic [DW-1:0]   in_stage;
  logic            in_done;
  logic            out_valid;
  logic [L*AW-1:0] bank_addr;
  logic [L*4-1:0]  bank_lane;
  logic [L*4-1:0]  lane_bank;
  logic [DW-1:0]   out_stage;
  logic            out_done;
  logic [AW-1:0]   grp_cnt;
  logic            stage_last;
  logic            conflict_err;
  logic            range_err;

  always #5 clk = ~clk;

  ntt_bank_mapper #(.D_WIDTH(DW), .LOGN(LOGN), .LANES(L), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_order_i(in_order),
    .in_stage_i(in_stage), .in_done_i(in_done), .out_valid_o(out_valid),
    .bank_addr_o(bank_addr), .bank_lane_o(bank_lane), .lane_bank_o(lane_bank),
    .out_stage_o(out_stage), .out_done_o(out_done), .grp_cnt_o(grp_cnt),
    .stage_last_o(stage_last), .conflict_err_o(conflict_err), .range_err_o(range_err)
  );

  typedef struct {
    logic [L*AW-1:0] addr;
    logic [L*4-1:0]  bl;
    logic [L*4-1:0]  lb;
    logic [DW-1:0]   stage;
    logic [AW-1:0]   grp;
    logic            last;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops one expectation per presented group.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected no group at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("bank_addr", 256'(bank_addr), 256'(e.addr));
        chk("bank_lane", 256'(bank_lane), 256'(e.bl));
        chk("lane_bank", 256'(lane_bank), 256'(e.lb));
        chk("out_stage", 256'(out_stage), 256'(e.stage));
        chk("grp_cnt", 256'(grp_cnt), 256'(e.grp));
        chk("stage_last", 256'(stage_last), 256'(e.last));
      end
    end
  end

  function automatic logic [L*DW-1:0] ident_order();
    logic [L*DW-1:0] o;
    for (int k = 0; k < L; k++) o[k*DW +: DW] = DW'(k * 256);
    return o;
  endfunction

  function automatic exp_t ident_exp(input int st, input int g);
    exp_t e;
    for (int b = 0; b < L; b++) begin
      e.addr[b*AW +: AW] = AW'(b * 16);
      e.bl[b*4 +: 4]     = 4'(b);
      e.lb[b*4 +: 4]     = 4'(b);
    end
    e.stage = DW'(st);
    e.grp   = AW'(g);
    e.last  = (g == 255);
    return e;
  endfunction

  task automatic issue(input logic [L*DW-1:0] o, input int st, input exp_t e);
    in_valid = 1'b1;
    in_order = o;
    in_stage = DW'(st);
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while (q.size() != 0 && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    chk(name, 256'(q.size()), 256'd0);
  endtask

  task automatic check_flags(input string name, input logic c, input logic r);
    @(negedge clk);
    chk({name, "_conflict"}, 256'(conflict_err), 256'(c));
    chk({name, "_range"}, 256'(range_err), 256'(r));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [L*DW-1:0] o;
    exp_t e;
    int kk;

    // 1: reset with in_valid high
    rst = 1'b1; in_valid = 1'b1; in_order = ident_order(); in_stage = 16'd5; in_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_bank_addr", 256'(bank_addr), 256'd0);
    chk("rst_bank_lane", 256'(bank_lane), 256'd0);
    chk("rst_lane_bank", 256'(lane_bank), 256'd0);
    chk("rst_misc", 256'({out_stage, out_done, grp_cnt, stage_last, conflict_err, range_err}), 256'd0);
    rst = 1'b0; in_valid = 1'b0; in_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 256'(out_valid), 256'd0);
    end
    @(posedge clk); #1;

    // 2: idx = k*256 -> identity mapping
    issue(ident_order(), 0, ident_exp(0, 0));

    // 3: idx = 0x120+k -> bank (3+k) mod 16, addr 0x12
    for (int k = 0; k < L; k++) begin
      o[k*DW +: DW] = DW'(16'h120 + k);
      e.lb[k*4 +: 4] = 4'((3 + k) % 16);
      e.bl[k*4 +: 4] = 4'((k + 13) % 16);
      e.addr[k*AW +: AW] = 8'h12;
    end
    e.stage = 16'd0; e.grp = 8'd1; e.last = 1'b0;
    issue(o, 0, e);

    // 3b: idx = 0xkkk -> bank 3k mod 16, addr 0x11*k, new stage restarts count
    for (int k = 0; k < L; k++) begin
      o[k*DW +: DW] = DW'((k << 8) | (k << 4) | k);
      e.lb[k*4 +: 4] = 4'((3 * k) % 16);
      kk = (11 * k) % 16;
      e.bl[k*4 +: 4] = 4'(kk);
      e.addr[k*AW +: AW] = AW'(17 * kk);
    end
    e.stage = 16'd2; e.grp = 8'd0; e.last = 1'b0;
    issue(o, 2, e);
    idle();
    drain("drain_a");
    check_flags("clean", 1'b0, 1'b0);

    // 4: all zero -> conflict, lane 0 wins bank 0
    e.addr = '0; e.bl = '0; e.lb = '0; e.stage = 16'd2; e.grp = 8'd1; e.last = 1'b0;
    issue('0, 2, e);
    idle();
    drain("drain_b");
    check_flags("conflict", 1'b1, 1'b0);
    o = ident_order();
    o[DW-1:0] = 16'h1000;
    issue(o, 2, ident_exp(2, 2));
    idle();
    drain("drain_c");
    check_flags("range", 1'b1, 1'b1);
    issue(ident_order(), 2, ident_exp(2, 3));
    idle();
    drain("drain_d");
    check_flags("sticky", 1'b1, 1'b1);

    // 5: reset, then 256 stage-0 groups and 3 stage-1 groups back to back
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_flags("rst_clear", 1'b0, 1'b0);
    for (int g = 0; g < 256; g++) issue(ident_order(), 0, ident_exp(0, g));
    for (int g = 0; g < 3; g++) issue(ident_order(), 1, ident_exp(1, g));
    idle();
    drain("drain_e");

    // 6: done pulse -> out_done two edges later, count cleared
    in_done = 1'b1;
    @(posedge clk); #1;
    in_done = 1'b0;
    @(negedge clk);
    chk("done_early", 256'(out_done), 256'd0);
    @(negedge clk);
    chk("done_pulse", 256'(out_done), 256'd1);
    chk("done_grp", 256'(grp_cnt), 256'd0);
    chk("done_last", 256'(stage_last), 256'd0);
    @(negedge clk);
    chk("done_end", 256'(out_done), 256'd0);
    @(posedge clk); #1;
    issue(ident_order(), 1, ident_exp(1, 0));
    idle();
    drain("drain_f");

    // reset mid-burst: first group emerges, the rest are dropped
    issue(ident_order(), 1, ident_exp(1, 1));
    in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_idle", 256'(out_valid), 256'd0);
    end
    chk("midrst_queue", 256'(q.size()), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
